// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit bundle between the multicycle controller and its datapath.
// The controller side is master (drives strobes/selects); the datapath side is slave.
interface multicycle_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_wre;
  logic       ir_wre;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       alu_src_b;
  logic       ext_sel;
  logic       reg_wre;
  logic [1:0] reg_dst;
  logic [1:0] db_src;
  logic       mem_wr;
  logic [3:0] state;
  logic       halted;

  modport master (
    input  opcode, zero,
    output pc_wre, ir_wre, pc_src, alu_op, alu_src_b, ext_sel,
           reg_wre, reg_dst, db_src, mem_wr, state, halted
  );

  modport slave (
    output opcode, zero,
    input  pc_wre, ir_wre, pc_src, alu_op, alu_src_b, ext_sel,
           reg_wre, reg_dst, db_src, mem_wr, state, halted
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: walks each instruction through IF/ID/EXE/MEM/WB and
// produces the datapath strobes, with exactly one pc_wre pulse per instruction.
module multicycle_ctrl_fsm #(
  parameter int RA_REG          = 31,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_AL = 4'b0010,
    S_WB_AL  = 4'b0011,
    S_EXE_BR = 4'b0100,
    S_EXE_LS = 4'b0101,
    S_MEM    = 4'b0110,
    S_WB_LD  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB = 6'b000001,
                         OP_AND  = 6'b010001, OP_OR  = 6'b010000,
                         OP_ADDI = 6'b000010, OP_ORI = 6'b010010,
                         OP_SW   = 6'b110000, OP_LW  = 6'b110001,
                         OP_BEQ  = 6'b110100, OP_BNE = 6'b110101,
                         OP_J    = 6'b111000, OP_JAL = 6'b111010,
                         OP_JR   = 6'b111001, OP_HALT = 6'b111111;

  // jal always writes through reg_dst=10; the index only has to be a real register.
  if (RA_REG < 0 || RA_REG > 31) begin : g_ra_range
    $error("RA_REG must be a register index 0..31");
  end

  state_t     state_q, state_nxt;
  logic [5:0] op_q;

  logic       pc_wre, ir_wre, alu_src_b, ext_sel, reg_wre, mem_wr, halted;
  logic [1:0] pc_src, reg_dst, db_src;
  logic [2:0] alu_op;

  // {alu_op, alu_src_b, ext_sel} for the ALU-class opcodes.
  function automatic logic [4:0] alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB:  alu_sel = {3'b001, 1'b0, 1'b0};
      OP_AND:  alu_sel = {3'b010, 1'b0, 1'b0};
      OP_OR:   alu_sel = {3'b011, 1'b0, 1'b0};
      OP_ADDI: alu_sel = {3'b000, 1'b1, 1'b1};
      OP_ORI:  alu_sel = {3'b011, 1'b1, 1'b0};
      default: alu_sel = {3'b000, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic logic is_rtype(input logic [5:0] op);
    is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= 6'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_ID) op_q <= bus.opcode;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    pc_src    = 2'b00;
    alu_op    = 3'b000;
    alu_src_b = 1'b0;
    ext_sel   = 1'b0;
    reg_wre   = 1'b0;
    reg_dst   = 2'b00;
    db_src    = 2'b00;
    mem_wr    = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IF: begin
        ir_wre    = 1'b1;
        state_nxt = S_ID;
      end
      // ID is the only state that looks at the live opcode; op_q is loaded here.
      S_ID: begin
        case (bus.opcode)
          OP_J:  begin pc_wre = 1'b1; pc_src = 2'b10; state_nxt = S_IF; end
          OP_JR: begin pc_wre = 1'b1; pc_src = 2'b11; state_nxt = S_IF; end
          OP_JAL: begin
            pc_wre    = 1'b1;
            pc_src    = 2'b10;
            reg_wre   = 1'b1;
            reg_dst   = 2'b10;
            db_src    = 2'b10;
            state_nxt = S_IF;
          end
          OP_HALT:        state_nxt = S_HALT;
          OP_BEQ, OP_BNE: state_nxt = S_EXE_BR;
          OP_LW, OP_SW:   state_nxt = S_EXE_LS;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ORI: state_nxt = S_EXE_AL;
          default: begin
            if (HALT_ON_ILLEGAL != 0) begin
              state_nxt = S_HALT;
            end else begin
              pc_wre    = 1'b1;
              state_nxt = S_IF;
            end
          end
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        {alu_op, alu_src_b, ext_sel} = alu_sel(op_q);
        if (state_q == S_WB_AL) begin
          reg_wre   = 1'b1;
          reg_dst   = is_rtype(op_q) ? 2'b01 : 2'b00;
          pc_wre    = 1'b1;
          state_nxt = S_IF;
        end else begin
          state_nxt = S_WB_AL;
        end
      end
      S_EXE_BR: begin
        alu_op = 3'b001;
        pc_wre = 1'b1;
        if ((op_q == OP_BEQ && bus.zero) || (op_q == OP_BNE && !bus.zero)) pc_src = 2'b01;
        state_nxt = S_IF;
      end
      S_EXE_LS, S_MEM: begin
        alu_op    = 3'b000;
        alu_src_b = 1'b1;
        ext_sel   = 1'b1;
        if (state_q == S_EXE_LS) begin
          state_nxt = S_MEM;
        end else if (op_q == OP_SW) begin
          mem_wr    = 1'b1;
          pc_wre    = 1'b1;
          state_nxt = S_IF;
        end else begin
          state_nxt = S_WB_LD;
        end
      end
      S_WB_LD: begin
        reg_wre   = 1'b1;
        db_src    = 2'b01;
        pc_wre    = 1'b1;
        state_nxt = S_IF;
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_IF;
    endcase

    // An instruction interrupted by reset must not touch PC, IR, regfile or memory.
    if (reset) begin
      pc_wre  = 1'b0;
      ir_wre  = 1'b0;
      reg_wre = 1'b0;
      mem_wr  = 1'b0;
    end
  end

  assign bus.pc_wre    = pc_wre;
  assign bus.ir_wre    = ir_wre;
  assign bus.pc_src    = pc_src;
  assign bus.alu_op    = alu_op;
  assign bus.alu_src_b = alu_src_b;
  assign bus.ext_sel   = ext_sel;
  assign bus.reg_wre   = reg_wre;
  assign bus.reg_dst   = reg_dst;
  assign bus.db_src    = db_src;
  assign bus.mem_wr    = mem_wr;
  assign bus.state     = state_q;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed instructions then random programs, each
// cycle checked against a per-instruction timeline model.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b010001, OR_ = 6'b010000,
                         ADDI = 6'b000010, ORI = 6'b010010, SW = 6'b110000, LW = 6'b110001,
                         BEQ = 6'b110100, BNE = 6'b110101, J = 6'b111000, JAL = 6'b111010,
                         JR = 6'b111001, HALT = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [5:0] ops [14] = '{ADD, SUB, AND_, OR_, ADDI, ORI, SW, LW, BEQ, BNE, J, JAL, JR, HALT};

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if ifa ();
  multicycle_ctrl_fsm_if ifb ();

  multicycle_ctrl_fsm #(.RA_REG(31), .HALT_ON_ILLEGAL(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  multicycle_ctrl_fsm #(.RA_REG(31), .HALT_ON_ILLEGAL(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Cycles from IF through the pc_wre cycle; 0 means the instruction ends in HALT.
  function automatic int ilen(input logic [5:0] op, input bit hill);
    case (op)
      J, JR, JAL:                       return 2;
      BEQ, BNE:                         return 3;
      SW, ADD, SUB, AND_, OR_, ADDI, ORI: return 4;
      LW:                               return 5;
      HALT:                             return 0;
      default:                          return hill ? 0 : 2;
    endcase
  endfunction

  function automatic bit is_def(input logic [5:0] op);
    for (int i = 0; i < 14; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected {state, halted, pc_wre, ir_wre, pc_src, alu_op, alu_src_b, ext_sel,
  // reg_wre, reg_dst, db_src, mem_wr} in cycle k of an instruction.
  function automatic logic [19:0] model(input logic [5:0] op, input logic z, input bit hill,
                                        input int k, input bit rst);
    logic [3:0] st;
    logic hl, pcw, irw, asb, ext, rw, mw;
    logic [1:0] ps, rd, db;
    logic [2:0] ao;
    int len;
    st = 4'd0; hl = 0; pcw = 0; irw = 0; asb = 0; ext = 0; rw = 0; mw = 0;
    ps = 2'b00; rd = 2'b00; db = 2'b00; ao = 3'b000;
    len = ilen(op, hill);
    if (k == 0) begin
      st = 4'd0; irw = 1;
    end else if (k == 1) begin
      st = 4'd1;
      if (op == J) ps = 2'b10;
      if (op == JR) ps = 2'b11;
      if (op == JAL) begin ps = 2'b10; rw = 1; rd = 2'b10; db = 2'b10; end
    end else if (len == 0) begin
      st = 4'd8; hl = 1;
    end else if (op == BEQ || op == BNE) begin
      st = 4'd4; ao = 3'b001;
      if ((op == BEQ && z) || (op == BNE && !z)) ps = 2'b01;
    end else if (op == SW || op == LW) begin
      st = 4'(3 + k);
      if (k < 4) begin ao = 3'b000; asb = 1; ext = 1; end
      if (op == SW && k == 3) mw = 1;
      if (k == 4) begin rw = 1; db = 2'b01; end
    end else begin
      st = 4'(k);
      case (op)
        SUB:  ao = 3'b001;
        AND_: ao = 3'b010;
        OR_:  ao = 3'b011;
        ADDI: begin ao = 3'b000; asb = 1; ext = 1; end
        ORI:  begin ao = 3'b011; asb = 1; ext = 0; end
        default: ao = 3'b000;
      endcase
      if (k == 3) begin rw = 1; rd = (op == ADDI || op == ORI) ? 2'b00 : 2'b01; end
    end
    if (len != 0 && k == len - 1) pcw = 1;
    if (rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    return {st, hl, pcw, irw, ps, ao, asb, ext, rw, rd, db, mw};
  endfunction

  task automatic check(input bit b, input string tag, input logic [19:0] e);
    logic [19:0] o;
    if (b) o = {ifb.state, ifb.halted, ifb.pc_wre, ifb.ir_wre, ifb.pc_src, ifb.alu_op,
                ifb.alu_src_b, ifb.ext_sel, ifb.reg_wre, ifb.reg_dst, ifb.db_src, ifb.mem_wr};
    else   o = {ifa.state, ifa.halted, ifa.pc_wre, ifa.ir_wre, ifa.pc_src, ifa.alu_op,
                ifa.alu_src_b, ifa.ext_sel, ifa.reg_wre, ifa.reg_dst, ifa.db_src, ifa.mem_wr};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  task automatic drive(input bit b, input logic [5:0] op, input logic z);
    if (b) begin ifb.opcode = op; ifb.zero = z; end
    else   begin ifa.opcode = op; ifa.zero = z; end
  endtask

  // Reset for one edge; returns #1 into the first IF cycle with reset low.
  task automatic do_reset(input bit b);
    reset = 1'b1;
    @(posedge clk); #1;
    check(b, "reset_state", model(6'b0, 1'b0, !b, 0, 1'b1));
    reset = 1'b0;
  endtask

  // Entered #1 into an instruction's IF cycle; leaves #1 into the next IF cycle.
  task automatic run_instr(input bit b, input logic [5:0] op, input logic z, input string name);
    int len, n;
    len = ilen(op, !b);
    n = (len == 0) ? 22 : len;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 0) drive(b, op, z);
      #1;
      check(b, $sformatf("%s op=%b z=%0d k=%0d", name, op, z, k), model(op, z, !b, k, 1'b0));
    end
    if (len == 0) do_reset(b);
    else begin @(posedge clk); #1; end
  endtask

  // sw interrupted by reset while in MEM.
  task automatic abort_sw(input bit b);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 0) drive(b, SW, 1'b0);
      #1;
      check(b, $sformatf("abort_sw k=%0d", k), model(SW, 1'b0, !b, k, 1'b0));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check(b, "abort_sw mem_under_reset", model(SW, 1'b0, !b, 3, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check(b, "abort_sw back_to_if", model(SW, 1'b0, !b, 0, 1'b0));
  endtask

  task automatic rand_prog(input bit b, input int count);
    logic [5:0] op;
    int r;
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 15);
      if (r < 14) op = ops[r];
      else begin
        op = 6'($urandom_range(0, 63));
        while (is_def(op)) op = 6'($urandom_range(0, 63));
      end
      run_instr(b, op, 1'($urandom_range(0, 1)), b ? "rnd_b" : "rnd_a");
    end
  endtask

  initial begin
    drive(1'b0, 6'b0, 1'b0);
    drive(1'b1, 6'b0, 1'b0);
    do_reset(1'b0);
    run_instr(1'b0, ADD, 1'b0, "add");
    run_instr(1'b0, BEQ, 1'b1, "beq_taken");
    run_instr(1'b0, BEQ, 1'b0, "beq_not");
    run_instr(1'b0, BNE, 1'b0, "bne_taken");
    run_instr(1'b0, BNE, 1'b1, "bne_not");
    run_instr(1'b0, LW, 1'b0, "lw");
    run_instr(1'b0, SW, 1'b0, "sw");
    run_instr(1'b0, JAL, 1'b0, "jal");
    run_instr(1'b0, JR, 1'b0, "jr");
    run_instr(1'b0, J, 1'b0, "j");
    run_instr(1'b0, SUB, 1'b0, "sub");
    run_instr(1'b0, AND_, 1'b0, "and");
    run_instr(1'b0, OR_, 1'b0, "or");
    run_instr(1'b0, ADDI, 1'b0, "addi");
    run_instr(1'b0, ORI, 1'b0, "ori");
    run_instr(1'b0, HALT, 1'b0, "halt");
    run_instr(1'b0, 6'b101010, 1'b0, "illegal_halts");
    abort_sw(1'b0);
    run_instr(1'b0, ADD, 1'b0, "after_abort");
    rand_prog(1'b0, 40);

    do_reset(1'b1);
    run_instr(1'b1, 6'b101010, 1'b0, "illegal_nop");
    run_instr(1'b1, ADDI, 1'b0, "b_addi");
    run_instr(1'b1, HALT, 1'b0, "b_halt");
    abort_sw(1'b1);
    rand_prog(1'b1, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multicycle control unit that sequences each instruction through IF/ID/EXE/MEM/WB states. It generates the datapath strobes, including the single-cycle pc_wre pulse and pc_src select consumed by the program-counter register. It sits directly upstream of the PC, IR, register file, ALU and data memory. It decodes the 6-bit opcode held in the IR and the ALU zero flag.

Parameters:
RA_REG, 31, register index written by jal (reported for bench use only; selection is made through reg_dst=10).
HALT_ON_ILLEGAL, 1, if 1 an undefined opcode enters HALT; if 0 it is treated as a 2-cycle nop.

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
opcode  in  6  IR[31:26], stable from the end of IF until the next IF
zero  in  1  ALU result==0, valid in EXE_BR
pc_wre  out  1  PC load strobe
ir_wre  out  1  IR load strobe
pc_src  out  2  00 pc+4, 01 branch target, 10 jump target, 11 rs (jr)
alu_op  out  3  000 add, 001 sub, 010 and, 011 or
alu_src_b  out  1  0 rt, 1 extended immediate
ext_sel  out  1  1 sign-extend, 0 zero-extend
reg_wre  out  1  register file write strobe
reg_dst  out  2  00 rt, 01 rd, 10 RA_REG
db_src  out  2  writeback data: 00 ALU, 01 memory, 10 pc+4
mem_wr  out  1  data memory write strobe
state  out  4  current state encoding, for debug
halted  out  1  high while in HALT

Behaviour:
- Opcodes: add 000000, sub 000001, and 010001, or 010000, addi 000010, ori 010010, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jal 111010, jr 111001, halt 111111.
- States and encodings: IF 0000, ID 0001, EXE_AL 0010, WB_AL 0011, EXE_BR 0100, EXE_LS 0101, MEM 0110, WB_LD 0111, HALT 1000.
- Opcode capture: in ID, opcode is registered into op_q. Later states decode op_q only.
- Output style: all outputs are combinational from (state, op_q). ID alone decodes the live opcode input. Any strobe not listed for a state is 0; select outputs default to 0.
- IF: ir_wre=1. Next state ID.
- ID, j/jr: pc_wre=1, pc_src=10 for j and 11 for jr. Next state IF.
- ID, jal: pc_wre=1, pc_src=10, reg_wre=1, reg_dst=10, db_src=10. Next state IF.
- ID, halt: next state HALT, no pc_wre.
- ID, other opcodes: beq/bne go to EXE_BR; lw/sw go to EXE_LS; the remaining defined opcodes go to EXE_AL.
- ID, illegal opcode: go to HALT if HALT_ON_ILLEGAL=1; otherwise pc_wre=1, pc_src=00, next state IF.
- EXE_AL: alu_op per opcode (addi→add, ori→or). alu_src_b=1 for addi/ori. ext_sel=1 for addi, 0 for ori. Next state WB_AL.
- WB_AL: holds the EXE_AL selects. reg_wre=1, reg_dst=01 for R-type and 00 for I-type, db_src=00, pc_wre=1, pc_src=00. Next state IF.
- EXE_BR: alu_op=sub, pc_wre=1. pc_src=01 if taken, else 00. Taken means beq with zero=1, or bne with zero=0. Next state IF.
- EXE_LS: alu_op=add, alu_src_b=1, ext_sel=1. Next state MEM.
- MEM: holds the EXE_LS selects. For sw: mem_wr=1, pc_wre=1, pc_src=00, next state IF. For lw: next state WB_LD.
- WB_LD: reg_wre=1, reg_dst=00, db_src=01, pc_wre=1, pc_src=00. Next state IF.
- HALT: all strobes 0, halted=1. Stays in HALT until reset.
- Instruction cycle counts (IF through pc_wre): j/jr/jal 2, beq/bne 3, sw 4, ALU ops 4, lw 5.
- pc_wre: exactly one cycle per instruction, in its final state. It is never high in IF. At most one of {pc_wre, ir_wre} is high in any cycle.
- Reset:
  - While reset=1, pc_wre, ir_wre, reg_wre and mem_wr are forced to 0.
  - At the clock edge where reset=1: state←IF, op_q←0.
  - Reset overrides every transition, including HALT and mid-instruction (e.g. during MEM of sw). The interrupted instruction produces no further strobes.
  - First cycle after reset deasserts: state=IF, ir_wre=1, halted=0, all other outputs 0.

Test Plan:
1. Reset, then add (000000): ir_wre=1 at cycle 0; states IF,ID,EXE_AL,WB_AL; cycle 3 has reg_wre=1, reg_dst=01, pc_wre=1, pc_src=00; back in IF at cycle 4.
2. beq with zero=1 → EXE_BR at cycle 2 with pc_wre=1, pc_src=01. Repeat with zero=0 → pc_src=00. bne with zero=0 → pc_src=01.
3. lw (110001): pc_wre only in cycle 4 (WB_LD) with db_src=01 and reg_wre=1. sw (110000): mem_wr=1 and pc_wre=1 in cycle 3, reg_wre=0 throughout.
4. jal (111010): in cycle 1 (ID), pc_wre=1, pc_src=10, reg_wre=1, reg_dst=10, db_src=10; next state IF. jr (111001) → pc_src=11 in ID.
5. halt (111111): halted=1 from cycle 2, state=1000, all strobes 0 for 20 cycles. Then reset=1 for 1 cycle → state=0000, ir_wre=1.
6. Reset asserted during MEM of sw → mem_wr=0 and pc_wre=0 in that cycle; next cycle state=IF. With HALT_ON_ILLEGAL=0, opcode 101010 → pc_wre=1 in ID, pc_src=00.
